am_envelope_decim: RTL and testbench
====================================

# am_envelope_decim

Envelope detection and decimation stage of the AM detector, sitting directly downstream of the clock-domain bridge that delivers signed ADC samples into the DSP clock domain. It full-wave rectifies each valid input sample, averages blocks of 2^LOG2_DECIM magnitudes with a boxcar accumulator, and presents one envelope value per block on a valid/ready output. It optionally removes the carrier's DC level from the envelope.

## Interface
- SAMPLE_W, 14: width of the signed input sample.
- LOG2_DECIM, 4: log2 of the decimation ratio; legal range 0..8, where 0 means one output per input.
- DC_SHIFT, 6: DC-tracker time constant, as a shift amount; legal range 1..12; used only with AM_DC_BLOCK_EN.

- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_data, input, SAMPLE_W: two's-complement sample from the bridge.
- in_valid, input, 1: in_data is a new sample this cycle.
- env_out, output, SAMPLE_W+1: two's-complement envelope value.
- env_valid, output, 1: env_out holds an unconsumed result.
- env_ready, input, 1: the consumer accepts env_out this cycle.
- ovf, output, 1: sticky flag; a result was dropped under backpressure.

## Operation
- Rectify: mag = |in_data|, unsigned SAMPLE_W bits. The input -2^(SAMPLE_W-1) maps to 2^(SAMPLE_W-1), which fits with no saturation. The result is registered together with a valid bit (stage 1).
- Accumulate: acc is SAMPLE_W+LOG2_DECIM bits unsigned, and cnt is LOG2_DECIM bits.
  - On each stage-1 valid with cnt ≠ 2^LOG2_DECIM−1: acc += mag and cnt++.
  - On the block's last sample: mean = (acc+mag) >> LOG2_DECIM, truncated. Then acc and cnt return to 0. cnt wraps naturally.
- Output register:
  - mean is loaded into env_out, zero-extended to SAMPLE_W+1 bits, and env_valid is set.
  - A transfer occurs when env_valid && env_ready. env_valid clears after a transfer unless a new result loads in the same cycle.
  - If a new result arrives while env_valid && !env_ready: keep the old value, discard the new one, and set ovf.
  - If a new result arrives in the same cycle as a transfer: load the new value with no drop and no ovf.
- ovf stays set until reset.
- Reset values: env_out = 0, env_valid = 0, ovf = 0. acc, cnt, the stage-1 register and the DC state are all cleared.
- Reset mid-block: the partial block is discarded, and the next block starts at the first in_valid after reset deasserts. in_valid is ignored while reset is high.
- in_valid gaps do not affect accumulation; only valid samples count.

## Timing
- The sample completing a block is registered at edge E. Its mean is visible with env_valid = 1 after edge E+2, or after edge E+3 with AM_DC_BLOCK_EN.
- Throughput is one input per clock, giving one result per 2^LOG2_DECIM valid inputs.
- env_ready is sampled at the rising edge. env_valid and env_out must not depend combinationally on env_ready.

## Configuration
- AM_DC_BLOCK_EN defined:
  - An extra registered stage computes y = mean − (dc_acc >>> DC_SHIFT).
  - It then updates dc_acc += y. dc_acc is signed SAMPLE_W+1+DC_SHIFT bits and is cleared by reset.
  - The update happens only when a result is produced.
  - y is in [−2^(SAMPLE_W-1), 2^(SAMPLE_W-1)] and is emitted as env_out.
  - The first result after reset equals mean.
- AM_DC_BLOCK_EN undefined:
  - No DC stage is built, and env_out = zero-extended mean with MSB always 0.
  - Latency is 2 cycles, and DC_SHIFT is unused.

## Structure
- Shared package am_detector_pkg holds:
  - the SAMPLE_W default constant (14);
  - the envelope word type, SAMPLE_W+1 signed;
  - the LOG2_DECIM and DC_SHIFT legal-range limits.
- The other stages of the AM detector use the same package.
- One sub-module, am_boxcar_decim, contains the accumulator, the counter and the mean computation. The top level holds the rectifier, the DC stage and the output handshake register.

## Test plan
- LOG2_DECIM=2, in_data constant 100 every cycle, env_ready=1 → env_out=100 every 4th cycle, first result 2 cycles after the 4th sample, ovf=0.
- LOG2_DECIM=2, in_data alternating +1000/−1000 with in_valid on every other cycle → env_out=1000 once per 8 clocks.
- LOG2_DECIM=0, in_data=−8192 → env_out=8192, ovf=0.
- LOG2_DECIM=2, env_ready=0 through two blocks → env_out keeps the first mean, env_valid=1, ovf=1. Raising env_ready in the same cycle a result loads must leave ovf=0.
- Reset asserted after 2 of 4 samples (inputs 400), then inputs 100 → first post-reset result 100; all outputs 0 during reset.
- AM_DC_BLOCK_EN, DC_SHIFT=4, LOG2_DECIM=0, constant 100 → first env_out 100, then non-increasing, settling to 0 within 200 results.

Source files
------------

// File: rtl/am_detector_pkg.sv
// Shared constants and types for the AM detector stages.
package am_detector_pkg;

    localparam int SAMPLE_W_DEF   = 14;
    localparam int LOG2_DECIM_MIN = 0;
    localparam int LOG2_DECIM_MAX = 8;
    localparam int DC_SHIFT_MIN   = 1;
    localparam int DC_SHIFT_MAX   = 12;

    typedef logic signed [SAMPLE_W_DEF:0] env_word_t;

    function automatic bit cfg_legal(input int log2_decim, input int dc_shift);
        return (log2_decim >= LOG2_DECIM_MIN) && (log2_decim <= LOG2_DECIM_MAX) &&
               (dc_shift >= DC_SHIFT_MIN) && (dc_shift <= DC_SHIFT_MAX);
    endfunction

endpackage

// File: rtl/am_boxcar_decim.sv
// Boxcar accumulator: sums 2^LOG2_DECIM magnitudes and emits their truncated mean.
module am_boxcar_decim
    import am_detector_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int LOG2_DECIM = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_mag_valid,
    input  logic [SAMPLE_W-1:0] i_mag,
    output logic                o_mean_valid,
    output logic [SAMPLE_W-1:0] o_mean
);

    localparam int ACC_W = SAMPLE_W + LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);

    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_mean;
    logic                r_mean_vld;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;

    // Running sum including the current sample; cannot overflow ACC_W.
    always_comb begin
        w_sum  = r_acc + ACC_W'(i_mag);
        w_last = (r_cnt == CNT_LAST);
    end

    // Accumulate, and on the block's last sample publish the mean and restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= {ACC_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_mean     <= {SAMPLE_W{1'b0}};
            r_mean_vld <= 1'b0;
        end else if (i_mag_valid) begin
            if (w_last) begin
                r_acc      <= {ACC_W{1'b0}};
                r_cnt      <= {CNT_W{1'b0}};
                r_mean     <= w_sum[ACC_W-1:LOG2_DECIM];
                r_mean_vld <= 1'b1;
            end else begin
                r_acc      <= w_sum;
                r_cnt      <= r_cnt + CNT_W'(1);
                r_mean_vld <= 1'b0;
            end
        end else begin
            r_mean_vld <= 1'b0;
        end
    end

    assign o_mean_valid = r_mean_vld;
    assign o_mean       = r_mean;

endmodule

// File: rtl/am_envelope_decim.sv
// AM envelope detector: rectify, boxcar-decimate, optional DC removal, valid/ready output.
// Optional DC tracker enabled by defining AM_DC_BLOCK_EN.
module am_envelope_decim
    import am_detector_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int LOG2_DECIM = 4,
    parameter int DC_SHIFT   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    output logic signed [SAMPLE_W:0]   env_out,
    output logic                       env_valid,
    input  logic                       env_ready,
    output logic                       ovf
);

    if (!cfg_legal(LOG2_DECIM, DC_SHIFT)) begin : g_cfg_illegal
        $error("am_envelope_decim: LOG2_DECIM or DC_SHIFT out of range");
    end

    logic [SAMPLE_W-1:0] w_in_u;
    logic [SAMPLE_W-1:0] w_mag;
    logic [SAMPLE_W-1:0] r_mag;
    logic                r_mag_vld;
    logic [SAMPLE_W-1:0] w_mean;
    logic                w_mean_vld;
    logic signed [SAMPLE_W:0] w_res;
    logic                w_res_vld;
    logic signed [SAMPLE_W:0] r_env;
    logic                r_env_vld;
    logic                r_ovf;

    // Full-wave rectifier; the most negative input maps exactly onto 2^(SAMPLE_W-1).
    always_comb begin
        w_in_u = in_data;
        if (w_in_u[SAMPLE_W-1]) begin
            w_mag = ~w_in_u + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end else begin
            w_mag = w_in_u;
        end
    end

    // Stage 1: registered magnitude with its valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag     <= {SAMPLE_W{1'b0}};
            r_mag_vld <= 1'b0;
        end else begin
            r_mag     <= w_mag;
            r_mag_vld <= in_valid;
        end
    end

    am_boxcar_decim #(
        .SAMPLE_W   (SAMPLE_W),
        .LOG2_DECIM (LOG2_DECIM)
    ) u_boxcar (
        .clk          (clk),
        .reset        (reset),
        .i_mag_valid  (r_mag_vld),
        .i_mag        (r_mag),
        .o_mean_valid (w_mean_vld),
        .o_mean       (w_mean)
    );

`ifdef AM_DC_BLOCK_EN
    localparam int DC_W = SAMPLE_W + 1 + DC_SHIFT;

    logic signed [DC_W-1:0]   r_dc_acc;
    logic signed [SAMPLE_W:0] r_dc_y;
    logic                     r_dc_vld;
    logic signed [SAMPLE_W:0] w_mean_ext;
    logic signed [SAMPLE_W:0] w_y;

    // The upper slice of dc_acc is dc_acc >>> DC_SHIFT and always fits SAMPLE_W+1 bits.
    always_comb begin
        w_mean_ext = {1'b0, w_mean};
        w_y        = w_mean_ext - r_dc_acc[DC_W-1:DC_SHIFT];
    end

    // DC tracker stage: updates only when a mean is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dc_acc <= {DC_W{1'b0}};
            r_dc_y   <= {(SAMPLE_W+1){1'b0}};
            r_dc_vld <= 1'b0;
        end else if (w_mean_vld) begin
            r_dc_acc <= r_dc_acc + {{DC_SHIFT{w_y[SAMPLE_W]}}, w_y};
            r_dc_y   <= w_y;
            r_dc_vld <= 1'b1;
        end else begin
            r_dc_vld <= 1'b0;
        end
    end

    assign w_res     = r_dc_y;
    assign w_res_vld = r_dc_vld;
`else
    assign w_res     = {1'b0, w_mean};
    assign w_res_vld = w_mean_vld;
`endif

    // Output holding register: a result arriving while a stalled one is held is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_env     <= {(SAMPLE_W+1){1'b0}};
            r_env_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_res_vld && r_env_vld && !env_ready) begin
            r_ovf <= 1'b1;
        end else if (w_res_vld) begin
            r_env     <= w_res;
            r_env_vld <= 1'b1;
        end else if (r_env_vld && env_ready) begin
            r_env_vld <= 1'b0;
        end else begin
            r_env_vld <= r_env_vld;
        end
    end

    assign env_out   = r_env;
    assign env_valid = r_env_vld;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_am_envelope_decim.sv
// Directed self-checking bench for am_envelope_decim (LOG2_DECIM=2 and LOG2_DECIM=0 instances).
module tb_am_envelope_decim;
    import am_detector_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [13:0]  in_data;
    logic                in_valid;
    logic                env_ready;
    env_word_t           env_out_2, env_out_0;
    logic                env_valid_2, env_valid_0, ovf_2, ovf_0;
    int                  checks = 0;
    int                  passed = 0;

    always #5 clk = ~clk;

    am_envelope_decim #(.SAMPLE_W(14), .LOG2_DECIM(2), .DC_SHIFT(4)) u_d2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .env_out(env_out_2), .env_valid(env_valid_2), .env_ready(env_ready), .ovf(ovf_2));

    am_envelope_decim #(.SAMPLE_W(14), .LOG2_DECIM(0), .DC_SHIFT(4)) u_d0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .env_out(env_out_0), .env_valid(env_valid_0), .env_ready(env_ready), .ovf(ovf_0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 14'sd4000; env_ready = 1'b1;
        step();
        step();
        reset = 1'b0; in_valid = 1'b0; in_data = 14'sd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 14'sd500; env_ready = 1'b1;
        for (int n = 0; n < 3; n++) step();
        checks++; if (env_out_2 !== 15'sd0) $display("FAIL reset_out2 got %0d want 0", env_out_2); else passed++;
        checks++; if (env_valid_2 !== 1'b0) $display("FAIL reset_vld2 got %b want 0", env_valid_2); else passed++;
        checks++; if (ovf_2 !== 1'b0) $display("FAIL reset_ovf2 got %b want 0", ovf_2); else passed++;
        checks++; if (env_out_0 !== 15'sd0) $display("FAIL reset_out0 got %0d want 0", env_out_0); else passed++;
        checks++; if (env_valid_0 !== 1'b0) $display("FAIL reset_vld0 got %b want 0", env_valid_0); else passed++;
        checks++; if (ovf_0 !== 1'b0) $display("FAIL reset_ovf0 got %b want 0", ovf_0); else passed++;
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_constant();
        logic exp_v;
        apply_reset();
        env_ready = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            in_valid = 1'b1; in_data = 14'sd100;
            step();
            exp_v = (n >= 6) && ((n - 6) % 4 == 0);
            checks++; if (env_valid_2 !== exp_v) $display("FAIL const_vld edge %0d got %b want %b", n, env_valid_2, exp_v); else passed++;
            if (exp_v) begin
                checks++; if (env_out_2 !== 15'sd100) $display("FAIL const_out edge %0d got %0d want 100", n, env_out_2); else passed++;
            end
            checks++; if (ovf_2 !== 1'b0) $display("FAIL const_ovf edge %0d got %b want 0", n, ovf_2); else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_alternating_gaps();
        logic exp_v;
        int   k;
        apply_reset();
        env_ready = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            in_valid = ((n - 1) % 2 == 0);
            k = (n - 1) / 2;
            in_data = (k % 2 == 1) ? -14'sd1000 : 14'sd1000;
            step();
            exp_v = (n == 9) || (n == 17) || (n == 25);
            checks++; if (env_valid_2 !== exp_v) $display("FAIL alt_vld edge %0d got %b want %b", n, env_valid_2, exp_v); else passed++;
            if (exp_v) begin
                checks++; if (env_out_2 !== 15'sd1000) $display("FAIL alt_out edge %0d got %0d want 1000", n, env_out_2); else passed++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_decim1_minval();
        apply_reset();
        env_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            in_valid = 1'b1; in_data = 14'h2000;
            step();
            checks++; if (env_valid_0 !== (n >= 3)) $display("FAIL d0_vld edge %0d got %b want %b", n, env_valid_0, (n >= 3)); else passed++;
            if (n >= 3) begin
                checks++; if (env_out_0 !== 15'sd8192) $display("FAIL d0_out edge %0d got %0d want 8192", n, env_out_0); else passed++;
            end
            checks++; if (ovf_0 !== 1'b0) $display("FAIL d0_ovf edge %0d got %b want 0", n, ovf_0); else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        env_ready = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            in_valid = (n <= 8);
            in_data  = (n <= 4) ? 14'sd100 : 14'sd200;
            step();
            if (n == 6) begin
                checks++; if (env_out_2 !== 15'sd100 || env_valid_2 !== 1'b1) $display("FAIL bp_first got %0d/%b want 100/1", env_out_2, env_valid_2); else passed++;
                checks++; if (ovf_2 !== 1'b0) $display("FAIL bp_ovf_early got %b want 0", ovf_2); else passed++;
            end
            if (n == 10) begin
                checks++; if (ovf_2 !== 1'b1) $display("FAIL bp_ovf_set got %b want 1", ovf_2); else passed++;
            end
        end
        checks++; if (env_out_2 !== 15'sd100) $display("FAIL bp_keep_old got %0d want 100", env_out_2); else passed++;
        checks++; if (env_valid_2 !== 1'b1) $display("FAIL bp_hold_vld got %b want 1", env_valid_2); else passed++;
        checks++; if (ovf_2 !== 1'b1) $display("FAIL bp_ovf_sticky got %b want 1", ovf_2); else passed++;
        env_ready = 1'b1;
        step();
        checks++; if (env_valid_2 !== 1'b0) $display("FAIL bp_drain got %b want 0", env_valid_2); else passed++;
        env_ready = 1'b0; reset = 1'b1;
        step();
        checks++; if (ovf_2 !== 1'b0 || env_valid_2 !== 1'b0 || env_out_2 !== 15'sd0)
            $display("FAIL bp_reset_clear got ovf=%b vld=%b out=%0d want 0/0/0", ovf_2, env_valid_2, env_out_2); else passed++;
        reset = 1'b0;

        apply_reset();
        env_ready = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            in_valid  = (n <= 8);
            in_data   = (n <= 4) ? 14'sd100 : 14'sd200;
            env_ready = (n == 10);
            step();
            if (n == 9) begin
                checks++; if (env_out_2 !== 15'sd100) $display("FAIL sim_first got %0d want 100", env_out_2); else passed++;
            end
            if (n >= 10) begin
                checks++; if (env_out_2 !== 15'sd200 || env_valid_2 !== 1'b1) $display("FAIL sim_load edge %0d got %0d/%b want 200/1", n, env_out_2, env_valid_2); else passed++;
                checks++; if (ovf_2 !== 1'b0) $display("FAIL sim_ovf edge %0d got %b want 0", n, ovf_2); else passed++;
            end
        end
        env_ready = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_mid_block_reset();
        apply_reset();
        env_ready = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            in_valid = 1'b1; in_data = 14'sd400;
            step();
        end
        reset = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            in_valid = 1'b1; in_data = 14'sd400;
            step();
            checks++; if (env_out_2 !== 15'sd0 || env_valid_2 !== 1'b0 || ovf_2 !== 1'b0)
                $display("FAIL mid_rst_zero got %0d/%b/%b want 0/0/0", env_out_2, env_valid_2, ovf_2); else passed++;
        end
        reset = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            in_valid = 1'b1; in_data = 14'sd100;
            step();
            if (n == 5) begin
                checks++; if (env_valid_2 !== 1'b0) $display("FAIL mid_rst_early got %b want 0", env_valid_2); else passed++;
            end
            if (n == 6) begin
                checks++; if (env_valid_2 !== 1'b1 || env_out_2 !== 15'sd100)
                    $display("FAIL mid_rst_first got %0d/%b want 100/1", env_out_2, env_valid_2); else passed++;
            end
        end
        in_valid = 1'b0;
    endtask

`ifdef AM_DC_BLOCK_EN
    task automatic test_dc_block();
        int        nres;
        int        rises;
        env_word_t prev;
        env_word_t first;
        env_word_t at200;
        apply_reset();
        env_ready = 1'b1;
        nres = 0; rises = 0; prev = '0; first = '0; at200 = 15'sd77;
        for (int n = 1; n <= 260; n++) begin
            in_valid = 1'b1; in_data = 14'sd100;
            step();
            if (env_valid_0 === 1'b1) begin
                nres++;
                if (nres == 1) first = env_out_0;
                else if (env_out_0 > prev) rises++;
                if (nres == 200) at200 = env_out_0;
                prev = env_out_0;
            end
        end
        checks++; if (first !== 15'sd100) $display("FAIL dc_first got %0d want 100", first); else passed++;
        checks++; if (rises != 0) $display("FAIL dc_monotonic got %0d rises want 0", rises); else passed++;
        checks++; if (nres < 200) $display("FAIL dc_count got %0d want >=200", nres); else passed++;
        checks++; if (at200 !== 15'sd0) $display("FAIL dc_settle got %0d want 0", at200); else passed++;
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 14'sd0; env_ready = 1'b1;
        test_reset();
`ifdef AM_DC_BLOCK_EN
        test_dc_block();
`else
        test_constant();
        test_alternating_gaps();
        test_decim1_minval();
        test_backpressure();
        test_mid_block_reset();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
